// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the single-port memory arbiter.
// State, access size and fairness defaults live here.
package riscv_mem_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] BUSY_IF = 2'b01;
  localparam logic [1:0] BUSY_DM = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memCmd_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants taken while a fetch waits.
// Raises forceFetch once the limit is reached.
module arb_starve_counter
  import riscv_mem_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ifReq,
  input  logic ifGrant,
  input  logic dmGrant,
  output logic forceFetch
);

  localparam int W =
    (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (ifGrant || !ifReq) begin
      count <= '0;
    end else if (dmGrant && count != LIM) begin
      count <= count + 1'b1;
    end
  end

  assign forceFetch = (count == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Fixed data priority with a starvation guard for fetch.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  logic [1:0]  state;
  memCmd_t     cmd;
  logic        killPending;
  logic        ifValidQ;
  logic        dmValidQ;
  logic [31:0] ifRdataQ;
  logic [31:0] dmRdataQ;

  logic isIdle;
  logic ifDone;
  logic dmDone;
  logic ifCand;
  logic dmWins;
  logic ifWins;
  logic ifGrant;
  logic dmGrant;
  logic forceFetch;
  logic ifDrop;

  assign isIdle = (state == IDLE);
  assign ifDone = (state == BUSY_IF) & mem_ready;
  assign dmDone = (state == BUSY_DM) & mem_ready;

  assign ifCand = if_req & ~if_kill;
  assign dmWins = dm_req & ~(forceFetch & ifCand);
  assign ifWins = ~dmWins & ifCand;

  // A requester still holds its old request in its valid cycle,
  // so the winner that just finished is not regranted then.
  assign dmGrant = isIdle & dmWins & ~dmValidQ;
  assign ifGrant = isIdle & ifWins & ~ifValidQ;

  assign ifDrop = killPending | if_kill;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) uStarve (
    .clk       (clk),
    .reset     (reset),
    .ifReq     (if_req),
    .ifGrant   (ifGrant),
    .dmGrant   (dmGrant),
    .forceFetch(forceFetch)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cmd      <= '0;
      ifValidQ <= 1'b0;
      dmValidQ <= 1'b0;
      ifRdataQ <= '0;
      dmRdataQ <= '0;
    end else begin
      ifValidQ <= 1'b0;
      dmValidQ <= 1'b0;
      unique case (1'b1)
        ifGrant: begin
          state <= BUSY_IF;
          cmd   <= '{we:    1'b0,
                     size:  SIZE_WORD,
                     addr:  if_addr,
                     wdata: 32'h0};
        end
        dmGrant: begin
          state <= BUSY_DM;
          cmd   <= '{we:    dm_we,
                     size:  dm_size,
                     addr:  dm_addr,
                     wdata: dm_wdata};
        end
        ifDone: begin
          state <= IDLE;
          if (!ifDrop) begin
            ifValidQ <= 1'b1;
            ifRdataQ <= mem_rdata;
          end
        end
        dmDone: begin
          state    <= IDLE;
          dmValidQ <= 1'b1;
          dmRdataQ <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // A killed fetch still finishes on the port; remember to drop it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      killPending <= 1'b0;
    end else if (ifDone) begin
      killPending <= 1'b0;
    end else if (state == BUSY_IF && if_kill) begin
      killPending <= 1'b1;
    end
  end

  assign mem_req   = ~isIdle;
  assign mem_we    = cmd.we;
  assign mem_size  = cmd.size;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  assign if_rdata = ifRdataQ;
  assign if_valid = ifValidQ;
  assign dm_rdata = dmRdataQ;
  assign dm_valid = dmValidQ;

  assign if_stall = if_req & ~ifValidQ;
  assign dm_stall = dm_req & ~dmValidQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Memory responder model plus scoreboard queues for fetch and data.
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        dm_req, dm_we;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_valid, dm_stall;
  logic        mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;
  int memLat = 1;
  bit memAuto = 1'b1;
  int ifValidCnt = 0;
  int dmValidCnt = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } grant_t;

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } dmExp_t;

  grant_t      grantQ[$];
  logic [31:0] ifExpQ[$];
  dmExp_t      dmExpQ[$];

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_kill  (if_kill),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .if_stall (if_stall),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_size  (dm_size),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .dm_stall (dm_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_size (mem_size),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h00500093;
      32'h100: return 32'hDEADBEEF;
      default: return a ^ 32'h5A5A0F0F;
    endcase
  endfunction

  // memory: mem_ready after memLat full cycles of mem_req
  initial begin
    int busy;
    busy = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (memAuto) begin
        if (mem_req && !reset) begin
          busy++;
          if (busy == memLat + 1) begin
            mem_ready = 1'b1;
            mem_rdata = memWord(mem_addr);
          end else begin
            mem_ready = 1'b0;
          end
        end else begin
          busy = 0;
          mem_ready = 1'b0;
        end
      end
    end
  end

  // monitor: grant log, command stability, scoreboard pops
  initial begin
    grant_t cur;
    logic prevReq;
    logic [31:0] ie;
    dmExp_t de;
    prevReq = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
        prevReq = 1'b0;
      end else begin
        if (mem_req && !prevReq) begin
          cur = '{mem_we, mem_size, mem_addr, mem_wdata, cyc};
          grantQ.push_back(cur);
        end else if (mem_req) begin
          totalCnt++;
          if ({mem_we, mem_size, mem_addr, mem_wdata} !==
              {cur.we, cur.size, cur.addr, cur.wdata})
            $display("FAIL cmd_stable: got %h/%b/%h/%h want %h/%b/%h/%h",
              mem_we, mem_size, mem_addr, mem_wdata,
              cur.we, cur.size, cur.addr, cur.wdata);
          else passCnt++;
        end
        prevReq = mem_req;
        if (if_valid) begin
          ifValidCnt++;
          totalCnt++;
          if (ifExpQ.size() == 0) begin
            $display("FAIL if_unexpected: if_rdata=%h with no fetch expected",
              if_rdata);
          end else begin
            ie = ifExpQ.pop_front();
            if (if_rdata !== ie)
              $display("FAIL if_rdata: got %h want %h", if_rdata, ie);
            else passCnt++;
          end
        end
        if (dm_valid) begin
          dmValidCnt++;
          totalCnt++;
          if (dmExpQ.size() == 0) begin
            $display("FAIL dm_unexpected: dm_rdata=%h with no access expected",
              dm_rdata);
          end else begin
            de = dmExpQ.pop_front();
            if (de.chk && dm_rdata !== de.data)
              $display("FAIL dm_rdata: got %h want %h", dm_rdata, de.data);
            else passCnt++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic waitFor(input int which, input int budget,
                         output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if ((which == 0 && mem_req) ||
          (which == 1 && if_valid) ||
          (which == 2 && dm_valid)) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    if_req = 0; if_kill = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_size = SIZE_WORD;
    dm_addr = '0; dm_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    totalCnt++;
    if (mem_req !== 1'b0)
      $display("FAIL rst_mem_req: got %b want 0", mem_req);
    else passCnt++;
    totalCnt++;
    if ({if_valid, dm_valid} !== 2'b00)
      $display("FAIL rst_valid: got %b want 00", {if_valid, dm_valid});
    else passCnt++;
    totalCnt++;
    if (if_rdata !== 32'h0)
      $display("FAIL rst_if_rdata: got %h want 0", if_rdata);
    else passCnt++;
    totalCnt++;
    if (dm_rdata !== 32'h0)
      $display("FAIL rst_dm_rdata: got %h want 0", dm_rdata);
    else passCnt++;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_lone_fetch;
    bit hit;
    bit stallOk;
    int n;
    memLat = 1;
    grantQ.delete();
    @(negedge clk);
    if_addr = 32'h10;
    if_req = 1'b1;
    ifExpQ.push_back(32'h00500093);
    waitFor(0, 10, hit);
    totalCnt++;
    if (hit !== 1'b1) $display("FAIL lone_req: got no mem_req want mem_req");
    else passCnt++;
    stallOk = if_stall;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n++;
      if (if_valid) begin hit = 1'b1; break; end
      if (!if_stall) stallOk = 1'b0;
    end
    totalCnt++;
    if (hit !== 1'b1 || n !== 2)
      $display("FAIL lone_latency: got hit=%0b cycles=%0d want 1/2", hit, n);
    else passCnt++;
    totalCnt++;
    if (stallOk !== 1'b1)
      $display("FAIL lone_stall: got low before if_valid want high");
    else passCnt++;
    totalCnt++;
    if (if_stall !== 1'b0)
      $display("FAIL lone_stall_valid: got %b want 0", if_stall);
    else passCnt++;
    if_req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_both;
    time dmT, ifT;
    bit hi, hd;
    memLat = 1;
    grantQ.delete();
    @(negedge clk);
    dm_we = 1'b0; dm_size = SIZE_WORD; dm_addr = 32'h100;
    dmExpQ.push_back('{1'b1, 32'hDEADBEEF});
    ifExpQ.push_back(memWord(32'h14));
    fork
      begin
        dm_req = 1'b1;
        waitFor(2, 40, hd);
        dmT = $time;
        dm_req = 1'b0;
      end
      begin
        if_addr = 32'h14;
        if_req = 1'b1;
        waitFor(1, 40, hi);
        ifT = $time;
        if_req = 1'b0;
      end
    join
    repeat (2) @(posedge clk);
    totalCnt++;
    if (!(hi && hd && dmT < ifT))
      $display("FAIL both_order: got dm@%0t if@%0t want dm first", dmT, ifT);
    else passCnt++;
    totalCnt++;
    if (grantQ.size() !== 2)
      $display("FAIL both_grants: got %0d want 2", grantQ.size());
    else passCnt++;
    totalCnt++;
    if (grantQ.size() < 2 ||
        grantQ[0].addr !== 32'h100 || grantQ[1].addr !== 32'h14)
      $display("FAIL both_grant_order: got wrong grant sequence want 100,14");
    else passCnt++;
  endtask

  task automatic test_starve;
    bit hi, hd;
    logic [31:0] expA[6];
    expA = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h300, 32'h200};
    memLat = 0;
    grantQ.delete();
    @(negedge clk);
    dm_we = 1'b0; dm_size = SIZE_WORD; dm_addr = 32'h200;
    if_addr = 32'h300;
    for (int i = 0; i < 5; i++)
      dmExpQ.push_back('{1'b1, memWord(32'h200)});
    ifExpQ.push_back(memWord(32'h300));
    fork
      begin
        dm_req = 1'b1;
        hd = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(posedge clk); #2;
          if (grantQ.size() >= 6) begin hd = 1'b1; break; end
        end
        if (hd) waitFor(2, 20, hd);
        dm_req = 1'b0;
      end
      begin
        if_req = 1'b1;
        waitFor(1, 200, hi);
        if_req = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    totalCnt++;
    if (!(hi && hd))
      $display("FAIL starve_done: got if=%0b dm=%0b want 1/1", hi, hd);
    else passCnt++;
    for (int i = 0; i < 6; i++) begin
      totalCnt++;
      if (grantQ.size() <= i)
        $display("FAIL starve_grant%0d: got none want %h", i, expA[i]);
      else if (grantQ[i].addr !== expA[i])
        $display("FAIL starve_grant%0d: got %h want %h",
          i, grantQ[i].addr, expA[i]);
      else passCnt++;
    end
  endtask

  task automatic test_kill;
    bit hit;
    int v0;
    memLat = 3;
    grantQ.delete();
    v0 = ifValidCnt;
    @(negedge clk);
    if_addr = 32'h40;
    if_req = 1'b1;
    if_kill = 1'b1;
    @(posedge clk); #1;
    totalCnt++;
    if (mem_req !== 1'b0)
      $display("FAIL kill_idle: got mem_req=%b want 0", mem_req);
    else passCnt++;
    @(negedge clk);
    if_kill = 1'b0;
    waitFor(0, 10, hit);
    if_kill = 1'b1;
    if_addr = 32'h80;
    ifExpQ.push_back(memWord(32'h80));
    @(posedge clk); #1;
    if_kill = 1'b0;
    waitFor(1, 40, hit);
    if_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    totalCnt++;
    if (hit !== 1'b1)
      $display("FAIL kill_refetch: got no if_valid want one");
    else passCnt++;
    totalCnt++;
    if (ifValidCnt - v0 !== 1)
      $display("FAIL kill_pulses: got %0d want 1", ifValidCnt - v0);
    else passCnt++;
    totalCnt++;
    if (grantQ.size() !== 2 || grantQ[0].addr !== 32'h40 ||
        grantQ[1].addr !== 32'h80)
      $display("FAIL kill_grants: got %0d grants want 40,80", grantQ.size());
    else passCnt++;
  endtask

  task automatic test_store;
    bit hit;
    int v0;
    memLat = 2;
    grantQ.delete();
    v0 = dmValidCnt;
    @(negedge clk);
    dm_we = 1'b1; dm_size = SIZE_HALF;
    dm_addr = 32'h202; dm_wdata = 32'h1234;
    dmExpQ.push_back('{1'b0, 32'h0});
    dm_req = 1'b1;
    waitFor(0, 10, hit);
    totalCnt++;
    if ({mem_we, mem_size, mem_addr, mem_wdata} !==
        {1'b1, 2'b01, 32'h202, 32'h1234})
      $display("FAIL store_cmd: got %b/%b/%h/%h want 1/01/202/1234",
        mem_we, mem_size, mem_addr, mem_wdata);
    else passCnt++;
    waitFor(2, 20, hit);
    dm_req = 1'b0;
    dm_we = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    totalCnt++;
    if (hit !== 1'b1 || dmValidCnt - v0 !== 1)
      $display("FAIL store_valid: got %0d pulses want 1", dmValidCnt - v0);
    else passCnt++;
  endtask

  task automatic test_reset_mid;
    bit hit;
    bit sawValid, sawReq;
    memAuto = 1'b0;
    mem_ready = 1'b0;
    grantQ.delete();
    @(negedge clk);
    dm_we = 1'b0; dm_size = SIZE_WORD; dm_addr = 32'h100;
    dm_req = 1'b1;
    waitFor(0, 10, hit);
    totalCnt++;
    if (hit !== 1'b1) $display("FAIL rmid_req: got no mem_req want mem_req");
    else passCnt++;
    @(negedge clk);
    reset = 1'b1;
    dm_req = 1'b0;
    #1;
    totalCnt++;
    if (mem_req !== 1'b0)
      $display("FAIL rmid_async: got mem_req=%b want 0", mem_req);
    else passCnt++;
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    mem_ready = 1'b0;
    sawValid = 1'b0;
    sawReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (dm_valid) sawValid = 1'b1;
      if (mem_req) sawReq = 1'b1;
    end
    totalCnt++;
    if ({sawValid, sawReq} !== 2'b00)
      $display("FAIL rmid_stale: got valid=%b req=%b want 0/0",
        sawValid, sawReq);
    else passCnt++;
    totalCnt++;
    if (dm_rdata !== 32'h0)
      $display("FAIL rmid_rdata: got %h want 0", dm_rdata);
    else passCnt++;
    memAuto = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_both();
    test_starve();
    test_kill();
    test_store();
    test_reset_mid();
    repeat (2) @(posedge clk);
    totalCnt++;
    if (ifExpQ.size() !== 0)
      $display("FAIL if_leftover: got %0d want 0", ifExpQ.size());
    else passCnt++;
    totalCnt++;
    if (dmExpQ.size() !== 0)
      $display("FAIL dm_leftover: got %0d want 0", dmExpQ.size());
    else passCnt++;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
